// File: rtl/stage_controller.sv
// stage_controller: decode sequencer that drives the global_stage bus for
// the PU array. It walks each context through load, grow/merge rounds,
// peeling and write-back. It reports completion, round latency and a
// grow-limit error.
module stage_controller #(
  parameter int PU_COUNT     = 16,
  parameter int NUM_CONTEXTS = 2,
  parameter int CTX_WIDTH    = 4,
  parameter int MERGE_MIN    = 3,
  parameter int MAX_GROW     = 15,
  parameter int CYCLE_WIDTH  = 16,
  parameter int STAGE_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   meas_valid,
  output logic                   meas_ready,
  input  logic [PU_COUNT-1:0]    busy_in,
  input  logic [PU_COUNT-1:0]    odd_in,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   local_context_switch,
  output logic [CTX_WIDTH-1:0]   context_id,
  output logic                   done,
  output logic                   error,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);

  // Stage codes shared with every PU
  localparam logic [STAGE_WIDTH-1:0] STG_IDLE   = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] STG_LOAD   = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] STG_GROW   = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] STG_MERGE  = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] STG_PEEL   = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] STG_WRITE  = STAGE_WIDTH'(5);
  localparam logic [STAGE_WIDTH-1:0] STG_RESULT = STAGE_WIDTH'(7);

  // Counter widths leave room for the limit value itself
  localparam int GROW_W  = $clog2(MAX_GROW + 2);
  localparam int MERGE_W = $clog2(MERGE_MIN + 2);

  localparam logic [GROW_W-1:0]    MAX_GROW_C  = GROW_W'(MAX_GROW);
  localparam logic [MERGE_W-1:0]   MERGE_MIN_C = MERGE_W'(MERGE_MIN);
  localparam logic [CTX_WIDTH-1:0] LAST_CTX    = CTX_WIDTH'(NUM_CONTEXTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GROW,
    S_MERGE,
    S_PEEL,
    S_WRITE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [GROW_W-1:0]      grow_cnt;
  logic [MERGE_W-1:0]     merge_cnt;
  logic                   idle_prev;
  logic [CYCLE_WIDTH-1:0] lat_cnt;
  logic [CYCLE_WIDTH-1:0] lat_nxt;
  logic                   error_nxt;
  logic [CTX_WIDTH-1:0]   ctx_nxt;
  logic                   handshake;
  logic                   pu_busy;
  logic                   pu_odd;
  logic                   merge_exit;

  // Stage broadcast for a given controller state; WAIT looks idle to the PUs
  function automatic logic [STAGE_WIDTH-1:0] stage_of(input state_t s);
    logic [STAGE_WIDTH-1:0] stg;
    case (s)
      S_LOAD:   stg = STG_LOAD;
      S_GROW:   stg = STG_GROW;
      S_MERGE:  stg = STG_MERGE;
      S_PEEL:   stg = STG_PEEL;
      S_WRITE:  stg = STG_WRITE;
      S_FINISH: stg = STG_RESULT;
      default:  stg = STG_IDLE;
    endcase
    return stg;
  endfunction

  // Latency counter increment that sticks at all-ones
  function automatic logic [CYCLE_WIDTH-1:0] sat_inc(input logic [CYCLE_WIDTH-1:0] v);
    return (&v) ? v : v + CYCLE_WIDTH'(1);
  endfunction

  assign handshake  = meas_valid & meas_ready;
  assign pu_busy    = |busy_in;
  assign pu_odd     = |odd_in;
  // The previous MERGE cycle was idle and this one is too, after the minimum dwell
  assign merge_exit = (merge_cnt >= MERGE_MIN_C) && idle_prev && !pu_busy;

  // Global switch only: PU memory address always advances on write-back
  assign local_context_switch = 1'b0;

  // Next-state, sticky error and context sequencing
  always_comb begin
    state_nxt = state;
    error_nxt = error;
    ctx_nxt   = context_id;
    case (state)
      S_IDLE: begin
        if (handshake) begin
          state_nxt = S_LOAD;
          error_nxt = 1'b0;
          ctx_nxt   = '0;
        end
      end
      S_LOAD:  state_nxt = S_GROW;
      S_GROW:  state_nxt = S_MERGE;
      S_MERGE: begin
        if (merge_exit) begin
          if (pu_odd && (grow_cnt < MAX_GROW_C)) begin
            state_nxt = S_GROW;
          end else begin
            if (pu_odd) error_nxt = 1'b1;
            state_nxt = S_PEEL;
          end
        end
      end
      S_PEEL:  state_nxt = S_WRITE;
      S_WRITE: begin
        if (context_id < LAST_CTX) begin
          ctx_nxt   = context_id + CTX_WIDTH'(1);
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_FINISH;
        end
      end
      S_WAIT: begin
        if (handshake) state_nxt = S_LOAD;
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
        ctx_nxt   = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Round latency: 1 in the first LOAD, then every cycle including WAIT
  always_comb begin
    lat_nxt = sat_inc(lat_cnt);
    if (state == S_IDLE) lat_nxt = handshake ? CYCLE_WIDTH'(1) : '0;
  end

  // State register and registered outputs, all derived from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      global_stage <= STG_IDLE;
      meas_ready   <= 1'b0;
      context_id   <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cycle_count  <= '0;
      lat_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      global_stage <= stage_of(state_nxt);
      meas_ready   <= (state_nxt == S_IDLE) || (state_nxt == S_WAIT);
      context_id   <= ctx_nxt;
      done         <= (state_nxt == S_FINISH);
      error        <= error_nxt;
      lat_cnt      <= lat_nxt;
      if (state_nxt == S_FINISH) cycle_count <= lat_nxt;
    end
  end

  // Grow iteration count per context, MERGE dwell and consecutive-idle tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grow_cnt  <= '0;
      merge_cnt <= '0;
      idle_prev <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        grow_cnt <= '0;
      end else if (state == S_GROW) begin
        grow_cnt <= grow_cnt + GROW_W'(1);
      end
      if (state == S_MERGE) begin
        if (merge_cnt < MERGE_MIN_C) merge_cnt <= merge_cnt + MERGE_W'(1);
        idle_prev <= !pu_busy;
      end else begin
        merge_cnt <= '0;
        idle_prev <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_controller.sv
// tb_stage_controller: two controller instances (two contexts with a short
// grow limit and narrow latency counter; one context with default limits)
// compared every cycle against a stage-level behavioural model.
module tb_stage_controller;

  localparam int PU   = 4;
  localparam int NC0  = 2;
  localparam int MG0  = 2;
  localparam int CW0  = 6;
  localparam int NC1  = 1;
  localparam int MG1  = 15;
  localparam int CW1  = 16;
  localparam int MMIN = 3;
  localparam int HMAX = 300;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          meas_valid = 1'b0;
  logic [PU-1:0] busy_in = '0;
  logic [PU-1:0] odd_in = '0;

  logic           rdy0, rdy1, lcs0, lcs1, dn0, dn1, er0, er1;
  logic [2:0]     st0, st1;
  logic [3:0]     ctx0, ctx1;
  logic [CW0-1:0] cc0;
  logic [CW1-1:0] cc1;

  always #5 clk = ~clk;

  stage_controller #(
    .PU_COUNT(PU), .NUM_CONTEXTS(NC0), .CTX_WIDTH(4), .MERGE_MIN(MMIN),
    .MAX_GROW(MG0), .CYCLE_WIDTH(CW0), .STAGE_WIDTH(3)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .meas_valid(meas_valid), .meas_ready(rdy0),
    .busy_in(busy_in), .odd_in(odd_in), .global_stage(st0),
    .local_context_switch(lcs0), .context_id(ctx0), .done(dn0), .error(er0),
    .cycle_count(cc0)
  );

  stage_controller #(
    .PU_COUNT(PU), .NUM_CONTEXTS(NC1), .CTX_WIDTH(4), .MERGE_MIN(MMIN),
    .MAX_GROW(MG1), .CYCLE_WIDTH(CW1), .STAGE_WIDTH(3)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .meas_valid(meas_valid), .meas_ready(rdy1),
    .busy_in(busy_in), .odd_in(odd_in), .global_stage(st1),
    .local_context_switch(lcs1), .context_id(ctx1), .done(dn1), .error(er1),
    .cycle_count(cc1)
  );

  int total;
  int bad;

  // Per-instance parameters seen by the model
  int p_nc[2]  = '{NC0, NC1};
  int p_mg[2]  = '{MG0, MG1};
  int p_max[2] = '{(1 << CW0) - 1, (1 << CW1) - 1};

  // Model: stage code on the bus, plus whether an idle bus means "between contexts"
  int m_st[2], m_ctx[2], m_cc[2], m_lat[2], m_gr[2], m_mc[2], m_run[2], m_ex[2];
  bit m_wait[2], m_rdy[2], m_dn[2], m_er[2];

  // Observation history for post-scenario literal checks
  int h_st[2][HMAX], h_ctx[2][HMAX], h_dn[2][HMAX], h_er[2][HMAX], h_cc[2][HMAX];
  int hlen;

  int seq_exp[10] = '{1, 2, 3, 3, 3, 3, 4, 5, 7, 0};

  // Stimulus modes
  int bm, om, vm, dly, wcnt;

  // Analysis results
  int a_ok, a_s, a_gr, a_wr, a_m1, a_cc, a_er;
  int a_wctx[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_ctx[i] = 0; m_cc[i] = 0; m_lat[i] = 0; m_gr[i] = 0;
      m_mc[i] = 0; m_run[i] = 0; m_ex[i] = 0;
      m_wait[i] = 0; m_rdy[i] = 0; m_dn[i] = 0; m_er[i] = 0;
    end
  endtask

  task automatic model_step();
    bit hs;
    for (int i = 0; i < 2; i++) begin
      hs = m_rdy[i] && meas_valid;
      if (m_st[i] == 0 && !m_wait[i]) m_lat[i] = hs ? 1 : 0;
      else m_lat[i] = (m_lat[i] < p_max[i]) ? m_lat[i] + 1 : p_max[i];
      m_dn[i] = 0;
      case (m_st[i])
        0: if (hs) begin
             if (!m_wait[i]) m_er[i] = 0;
             m_wait[i] = 0;
             m_st[i] = 1;
           end
        1: begin m_st[i] = 2; m_gr[i] = 0; end
        2: begin m_gr[i]++; m_st[i] = 3; m_mc[i] = 0; m_run[i] = 0; end
        3: begin
             m_run[i] = (busy_in != 0) ? 0 : m_run[i] + 1;
             if (m_mc[i] >= MMIN && m_run[i] >= 2) begin
               m_ex[i]++;
               if (odd_in != 0 && m_gr[i] < p_mg[i]) m_st[i] = 2;
               else begin
                 if (odd_in != 0) m_er[i] = 1;
                 m_st[i] = 4;
               end
             end else m_mc[i]++;
           end
        4: m_st[i] = 5;
        5: if (m_ctx[i] < p_nc[i] - 1) begin
             m_ctx[i]++; m_st[i] = 0; m_wait[i] = 1;
           end else begin
             m_st[i] = 7; m_dn[i] = 1; m_cc[i] = m_lat[i];
           end
        7: begin m_st[i] = 0; m_ctx[i] = 0; end
        default: m_st[i] = 0;
      endcase
      m_rdy[i] = (m_st[i] == 0);
    end
  endtask

  task automatic check_all();
    chk("stage0", int'(st0), m_st[0]);
    chk("ready0", int'(rdy0), int'(m_rdy[0]));
    chk("ctx0", int'(ctx0), m_ctx[0]);
    chk("done0", int'(dn0), int'(m_dn[0]));
    chk("error0", int'(er0), int'(m_er[0]));
    chk("cycles0", int'(cc0), m_cc[0]);
    chk("lcs0", int'(lcs0), 0);
    chk("stage1", int'(st1), m_st[1]);
    chk("ready1", int'(rdy1), int'(m_rdy[1]));
    chk("ctx1", int'(ctx1), m_ctx[1]);
    chk("done1", int'(dn1), int'(m_dn[1]));
    chk("error1", int'(er1), int'(m_er[1]));
    chk("cycles1", int'(cc1), m_cc[1]);
    chk("lcs1", int'(lcs1), 0);
    if (hlen < HMAX) begin
      h_st[0][hlen] = int'(st0); h_ctx[0][hlen] = int'(ctx0); h_dn[0][hlen] = int'(dn0);
      h_er[0][hlen] = int'(er0); h_cc[0][hlen] = int'(cc0);
      h_st[1][hlen] = int'(st1); h_ctx[1][hlen] = int'(ctx1); h_dn[1][hlen] = int'(dn1);
      h_er[1][hlen] = int'(er1); h_cc[1][hlen] = int'(cc1);
      hlen++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_inputs();
    case (bm)
      0: busy_in = '0;
      1: busy_in = (m_st[1] == 3 && m_mc[1] < 6) ? 4'b0010 : 4'b0000;
      2: busy_in = (m_st[1] == 3 && (m_mc[1] == 0 || m_mc[1] == 1 || m_mc[1] == 3))
                   ? 4'b0010 : 4'b0000;
      default: busy_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
    endcase
    case (om)
      0: odd_in = '0;
      1: odd_in = (m_ex[1] < 2) ? 4'b0001 : 4'b0000;
      2: odd_in = 4'b0001;
      default: odd_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
    endcase
    if (vm != 0) begin
      meas_valid = 1'($urandom_range(0, 1));
    end else if (m_st[0] == 0 && m_wait[0]) begin
      meas_valid = (wcnt >= dly);
      wcnt++;
    end else begin
      meas_valid = 1'b1;
      wcnt = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    meas_valid = 1'b0; busy_in = '0; odd_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_all();
    reset_n = 1'b1;
    hlen = 0;
    wcnt = 0;
  endtask

  // Reset dropped between clock edges: outputs must clear without waiting for clk
  task automatic async_reset();
    #3 reset_n = 1'b0;
    #1;
    chk("arst_stage0", int'(st0), 0);
    chk("arst_stage1", int'(st1), 0);
    chk("arst_ready0", int'(rdy0), 0);
    chk("arst_ready1", int'(rdy1), 0);
    chk("arst_done0", int'(dn0), 0);
    chk("arst_done1", int'(dn1), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic run_scn(input int b, input int o, input int d, input int n);
    bm = b; om = o; vm = 0; dly = d;
    do_reset();
    for (int k = 0; k < n; k++) begin
      set_inputs();
      tick();
    end
  endtask

  // Summarise the first round (first LOAD up to first RESULT_VALID) of instance i
  task automatic analyze(input int i);
    int s, e, f;
    a_ok = 0; a_s = 0; a_gr = 0; a_wr = 0; a_m1 = 0; a_cc = -1; a_er = -1;
    a_wctx[0] = -1; a_wctx[1] = -1;
    s = -1; e = -1; f = -1;
    for (int k = 0; k < hlen; k++) if (s < 0 && h_st[i][k] == 1) s = k;
    if (s >= 0) for (int k = s; k < hlen; k++) if (e < 0 && h_st[i][k] == 7) e = k;
    if (e >= 0) begin
      a_ok = 1; a_s = s;
      for (int k = s; k <= e; k++) begin
        if (h_st[i][k] == 2) a_gr++;
        if (h_st[i][k] == 5) begin
          if (a_wr < 2) a_wctx[a_wr] = h_ctx[i][k];
          a_wr++;
        end
        if (f < 0 && h_st[i][k] == 3) f = k;
      end
      for (int k = f; k <= e && h_st[i][k] == 3; k++) a_m1++;
      a_cc = h_cc[i][e];
      a_er = h_er[i][e];
    end
  endtask

  initial begin
    int reached;
    total = 0; bad = 0; hlen = 0;
    bm = 0; om = 0; vm = 0; dly = 0; wcnt = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_stage", int'(st0), 0);
    chk("rst_ready", int'(rdy0), 0);
    chk("rst_cycles", int'(cc1), 0);
    chk("rst_error", int'(er1), 0);

    // Quiet array, one context: 1,2,3,3,3,3,4,5,7,0 and latency 9
    run_scn(0, 0, 0, 100);
    analyze(1);
    chk("s1_found", a_ok, 1);
    for (int k = 0; k < 10; k++) begin
      chk("s1_seq", h_st[1][a_s + k], seq_exp[k]);
      chk("s1_donepulse", h_dn[1][a_s + k], int'(k == 8));
    end
    chk("s1_cycles", a_cc, 9);
    chk("s1_grows", a_gr, 1);
    analyze(0);
    chk("s1_i0_writes", a_wr, 2);
    chk("s1_i0_wctx0", a_wctx[0], 0);
    chk("s1_i0_wctx1", a_wctx[1], 1);
    chk("s1_i0_cycles", a_cc, 18);

    // Busy for the first 6 MERGE cycles stretches MERGE to 8
    run_scn(1, 0, 0, 100);
    analyze(1);
    chk("s2_merge_len", a_m1, 8);
    chk("s2_cycles", a_cc, 13);

    // Busy glitch after one idle cycle restarts the idle requirement
    run_scn(2, 0, 0, 100);
    analyze(1);
    chk("s3_merge_len", a_m1, 6);
    chk("s3_cycles", a_cc, 11);

    // Odd on the first two merge exits: three grows, error sticky across WAIT on the short limit
    run_scn(0, 1, 0, 100);
    analyze(1);
    chk("s4_grows", a_gr, 3);
    chk("s4_error", a_er, 0);
    chk("s4_cycles", a_cc, 19);
    analyze(0);
    chk("s4_i0_grows", a_gr, 3);
    chk("s4_i0_error", a_er, 1);

    // Odd stuck at 1, five-cycle upstream delay in WAIT
    run_scn(0, 2, 5, 100);
    analyze(0);
    chk("s5_i0_grows", a_gr, 4);
    chk("s5_i0_writes", a_wr, 2);
    chk("s5_i0_wctx0", a_wctx[0], 0);
    chk("s5_i0_wctx1", a_wctx[1], 1);
    chk("s5_i0_error", a_er, 1);
    chk("s5_i0_cycles", a_cc, 33);
    analyze(1);
    chk("s5_grows", a_gr, 15);
    chk("s5_error", a_er, 1);
    chk("s5_cycles", a_cc, 79);

    // Long WAIT saturates the 6-bit latency counter
    run_scn(0, 0, 60, 100);
    analyze(0);
    chk("s6_i0_cycles_sat", a_cc, 63);

    // Reset mid-MERGE, then a fresh round starting at context 0
    run_scn(0, 0, 0, 0);
    reached = 0;
    for (int k = 0; k < 40 && reached == 0; k++) begin
      set_inputs();
      tick();
      if (m_st[1] == 3 && m_mc[1] == 2) reached = 1;
    end
    chk("s7_reach_merge", reached, 1);
    async_reset();
    hlen = 0; wcnt = 0;
    for (int k = 0; k < 40; k++) begin
      set_inputs();
      tick();
    end
    analyze(0);
    chk("s7_i0_wctx0", a_wctx[0], 0);
    chk("s7_i0_cycles", a_cc, 18);

    // Randomised traffic with occasional asynchronous resets
    bm = 3; om = 3; vm = 1;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      set_inputs();
      tick();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_controller.md
Name: stage_controller

Overview:
- Single-FPGA decode sequencer that drives the global_stage bus consumed by every processing unit (PU) in the array.
- Collects the per-PU busy and odd flags and steps each context through measurement loading, repeated grow/merge rounds, peeling and write-to-memory.
- Reports completion, decode latency and a watchdog error to the host-side result logic.

Parameters:
PU_COUNT, 16, number of PUs whose busy/odd flags are collected
NUM_CONTEXTS, 2, contexts decoded sequentially per round (1..16)
CTX_WIDTH, 4, width of context_id
MERGE_MIN, 3, minimum cycles spent in STAGE_MERGE before exit is allowed (covers PU stage register plus busy register)
MAX_GROW, 15, grow iterations allowed per context before error
CYCLE_WIDTH, 16, width of cycle_count
STAGE_WIDTH, 3, stage bus width, shared stage encodings: IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3, PEELING=4, WRITE_TO_MEM=5, READ_FROM_MEM=6, RESULT_VALID=7

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
meas_valid  input  1  upstream has a syndrome for the current context
meas_ready  output  1  controller accepts syndrome
busy_in  input  PU_COUNT  per-PU busy flags
odd_in  input  PU_COUNT  per-PU odd-cluster flags
global_stage  output  STAGE_WIDTH  registered stage broadcast to the PUs
local_context_switch  output  1  context-switch type; driven 0 (global switch, so PU memory address advances)
context_id  output  CTX_WIDTH  context currently being decoded
done  output  1  one-cycle pulse, all contexts decoded
error  output  1  sticky; MAX_GROW exceeded in this round
cycle_count  output  CYCLE_WIDTH  latency of the last round

Behaviour:
- Reset is asynchronous and active-low. Whenever reset_n=0: state=IDLE, global_stage=IDLE, meas_ready=0, context_id=0, done=0, error=0, cycle_count=0, all counters 0. A reset mid-round aborts the round; no done pulse is produced.
- All outputs are registered. global_stage changes only on a clk edge.
- FSM states and the stage each one drives:
  - IDLE (stage IDLE): meas_ready=1. On meas_valid&&meas_ready go to LOAD. Clear error, clear the cycle counter, context_id=0.
  - LOAD (stage MEASUREMENT_LOADING, 1 cycle): go to GROW. Clear grow_cnt.
  - GROW (stage GROW, exactly 1 cycle, so each PU sees a single GROW edge): grow_cnt+=1, go to MERGE.
  - MERGE (stage MERGE): merge_cnt counts from 0.
    - Exit is allowed when merge_cnt>=MERGE_MIN and |busy_in==0 on two consecutive cycles.
    - On exit, if |odd_in==1 and grow_cnt<MAX_GROW, go to GROW.
    - On exit, if |odd_in==1 and grow_cnt==MAX_GROW, set error and go to PEEL.
    - On exit otherwise, go to PEEL.
  - PEEL (stage PEELING, 1 cycle): go to WRITE.
  - WRITE (stage WRITE_TO_MEM, 1 cycle, local_context_switch=0):
    - If context_id<NUM_CONTEXTS-1: context_id+=1, go to WAIT.
    - Otherwise go to FINISH.
  - WAIT (stage IDLE): meas_ready=1. On handshake go to LOAD.
  - FINISH (stage RESULT_VALID, 1 cycle): done=1, cycle_count=counter, go to IDLE.
- meas_ready is 1 only in IDLE and WAIT, and never in the cycle after an accepted handshake. Upstream holds the measurement bits stable from acceptance until meas_ready next rises.
- Latency counter:
  - Starts at 1 in the LOAD following the first handshake and increments every cycle through FINISH.
  - Saturates at all-ones.
  - Counts the cycles spent in WAIT.
  - cycle_count holds its value until the next FINISH or reset.
- busy_in and odd_in are ignored outside MERGE.
- The consecutive-idle tracker resets on any busy cycle and on MERGE entry.
- NUM_CONTEXTS=1 skips WAIT: WRITE goes directly to FINISH.

Test Plan:
- Reset mid-MERGE: drop reset_n asynchronously between edges -> global_stage=0, meas_ready=0 and done=0 immediately; next handshake starts at context 0.
- PU_COUNT=4, NUM_CONTEXTS=1, odd_in=0, busy_in=0 throughout, meas_valid at cycle 0 -> stage sequence 1,2,3,3,3,3,4,5,7,0. done pulses once. cycle_count=9. No second GROW.
- busy_in=4'b0010 for the first 6 MERGE cycles, then 0 -> MERGE lasts 8 cycles. A single-cycle busy glitch after 1 idle cycle restarts the 2-cycle idle requirement.
- odd_in=4'b0001 for the first 2 merge exits, then 0 -> exactly 3 GROW pulses, each 1 cycle. error=0.
- MAX_GROW=2, odd_in stuck at 1 -> 2 GROW stages, then PEELING. error=1 until the next IDLE handshake. done still pulses.
- NUM_CONTEXTS=2, meas_valid delayed 5 cycles in WAIT -> context_id 0 then 1. Two WRITE_TO_MEM stages with local_context_switch=0. meas_ready high only in IDLE/WAIT. cycle_count includes the 5 wait cycles.
